// File: rtl/kalman_frame_sequencer.sv
// kalman_frame_sequencer: per-frame launch, state feedback and buffered output stream for the Kalman core
module kalman_frame_sequencer #(
    parameter int COL        = 96,
    parameter int STATE_N    = 2,
    parameter int DATA_W     = 32,
    parameter int N_FRAMES   = 140,
    parameter int GAP_CYC    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              run_i,
    input  logic                              abort_i,
    input  logic                              mode_i,
    input  logic [STATE_N*DATA_W-1:0]         x_init_i,
    input  logic [$clog2(COL):0]              core_obs_idx_i,
    input  logic [$clog2(COL*COL):0]          core_k_addr_i,
    output logic [$clog2(COL*N_FRAMES):0]     z_addr_o,
    output logic [$clog2(COL*COL*N_FRAMES):0] k_addr_o,
    output logic                              core_start_o,
    output logic [STATE_N*DATA_W-1:0]         core_state_o,
    input  logic                              core_v_i,
    input  logic [DATA_W-1:0]                 core_d_i,
    input  logic                              core_finish_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [DATA_W-1:0]                 out_data_o,
    output logic [$clog2(N_FRAMES):0]         out_frame_o,
    output logic                              out_last_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              overflow_o
);
    localparam int FW  = $clog2(N_FRAMES) + 1;
    localparam int EW  = $clog2(STATE_N) + 1;
    localparam int GW  = $clog2(GAP_CYC) + 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int PC  = PW + 1;
    localparam int SW  = STATE_N * DATA_W;
    localparam int RW  = FW + 1 + DATA_W;
    localparam int ZW  = $clog2(COL*N_FRAMES) + 1;
    localparam int KAW = $clog2(COL*COL*N_FRAMES) + 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, GAP, DONE} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [EW-1:0]   elem_q, elem_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [SW-1:0]   xs_q, xs_d;
    logic            mode_q, mode_d;
    logic            ovf_q, ovf_d;
    logic [PW:0]     wr_q, wr_d, rd_q, rd_d;
    logic [RW-1:0]   mem_q [FIFO_DEPTH];
    logic [RW-1:0]   mem_d [FIFO_DEPTH];
    logic [PW:0]     count;
    logic            full, can_launch, push, pop, last;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count        = wr_q - rd_q;
    assign full         = count == PC'(FIFO_DEPTH);
    assign can_launch   = (PC'(FIFO_DEPTH) - count) >= PC'(STATE_N);
    assign out_valid_o  = count != '0;
    assign pop          = out_valid_o && out_ready_i;
    assign last         = elem_q == EW'(STATE_N - 1);
    assign push         = state_q == WAIT && core_v_i && !abort_i;
    assign {out_frame_o, out_last_o, out_data_o} = mem_q[rd_q[PW-1:0]];
    assign z_addr_o     = ZW'(frame_q * COL) + ZW'(core_obs_idx_i);
    assign k_addr_o     = KAW'(frame_q * (COL*COL)) + KAW'(core_k_addr_i);
    assign core_state_o = xs_q;
    assign busy_o       = state_q != IDLE && state_q != DONE;
    assign overflow_o   = ovf_q;

    // Word capture, FIFO bookkeeping and frame sequencing; abort overrides every transition.
    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        elem_d       = elem_q;
        gap_d        = gap_q;
        xs_d         = xs_q;
        mode_d       = mode_q;
        ovf_d        = ovf_q;
        wr_d         = wr_q;
        rd_d         = pop ? rd_q + 1'b1 : rd_q;
        mem_d        = mem_q;
        core_start_o = 1'b0;
        done_o       = 1'b0;
        if (push) begin
            xs_d[elem_q*DATA_W +: DATA_W] = core_d_i;
            elem_d = last ? '0 : elem_q + 1'b1;
            if (!full || pop) begin
                mem_d[wr_q[PW-1:0]] = {frame_q, last, core_d_i};
                wr_d = wr_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (abort_i) begin
            state_d = IDLE;
            wr_d    = '0;
            rd_d    = '0;
        end else begin
            case (state_q)
                IDLE: if (run_i) begin
                    state_d = LAUNCH;
                    xs_d    = x_init_i;
                    frame_d = '0;
                    elem_d  = '0;
                    ovf_d   = 1'b0;
                    mode_d  = mode_i;
                end
                LAUNCH: if (can_launch) begin
                    core_start_o = 1'b1;
                    state_d      = WAIT;
                end
                WAIT: if (core_finish_i) begin
                    elem_d = '0;
                    if (frame_q == FW'(N_FRAMES - 1) && !mode_q) begin
                        state_d = DONE;
                    end else begin
                        frame_d = frame_q == FW'(N_FRAMES - 1) ? '0 : frame_q + 1'b1;
                        gap_d   = GW'(GAP_CYC - 1);
                        state_d = GAP_CYC == 1 ? LAUNCH : GAP;
                    end
                end
                GAP: begin
                    gap_d   = gap_q - 1'b1;
                    state_d = gap_q <= GW'(1) ? LAUNCH : GAP;
                end
                DONE: begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            frame_q <= '0;
            elem_q  <= '0;
            gap_q   <= '0;
            xs_q    <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            elem_q  <= elem_d;
            gap_q   <= gap_d;
            xs_q    <= xs_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: tb/tb_kalman_frame_sequencer.sv
// tb_kalman_frame_sequencer: randomized bench with a queue-based reference model of the frame sequencer
module tb_kalman_frame_sequencer;
    localparam int COL = 96, SN = 2, DW = 32, NF = 3, GAP = 3, DEP = 2;

    logic clk = 0, rst_n = 0, run_i = 0, abort_i = 0, mode_i = 0;
    logic core_v_i = 0, core_finish_i = 0, out_ready_i = 0;
    logic [SN*DW-1:0] x_init_i = '0;
    logic [7:0]  obs_i = '0;
    logic [14:0] kad_i = '0;
    logic [DW-1:0] core_d_i = '0;
    logic [9:0]  z_addr_o;
    logic [15:0] k_addr_o;
    logic core_start_o, out_valid_o, out_last_o, busy_o, done_o, overflow_o;
    logic [SN*DW-1:0] core_state_o;
    logic [DW-1:0] out_data_o;
    logic [2:0] out_frame_o;

    kalman_frame_sequencer #(.COL(COL), .STATE_N(SN), .DATA_W(DW), .N_FRAMES(NF),
                             .GAP_CYC(GAP), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n), .run_i(run_i), .abort_i(abort_i), .mode_i(mode_i),
        .x_init_i(x_init_i), .core_obs_idx_i(obs_i), .core_k_addr_i(kad_i),
        .z_addr_o(z_addr_o), .k_addr_o(k_addr_o), .core_start_o(core_start_o),
        .core_state_o(core_state_o), .core_v_i(core_v_i), .core_d_i(core_d_i),
        .core_finish_i(core_finish_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_frame_o(out_frame_o), .out_last_o(out_last_o),
        .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [2:0] f; logic l; logic [DW-1:0] d;} word_t;

    word_t q[$];
    word_t dut_log[$];
    logic [DW-1:0] ms [SN];
    int mframe = 0, melem = 0, cyc = 0, launch_at = 0, done_at = -1, fin_cyc = 0;
    bit active = 0, pending = 0, waiting = 0, mmode = 0, movf = 0;
    int checks = 0, fails = 0, ndone = 0, nstarts = 0, gap_seen = 0, st_at = 0;
    int rdy_mode = 0;
    bit fix_addr = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", n, cyc, a, e);
        end
    endtask

    function automatic bit exp_start_f();
        return pending && cyc >= launch_at && (DEP - q.size()) >= SN && !abort_i;
    endfunction

    // Reference model: spec rules as a word queue plus launch/done timing.
    always @(posedge clk or negedge rst_n) begin
        bit st;
        word_t w;
        if (!rst_n) begin
            q.delete();
            foreach (ms[i]) ms[i] = '0;
            mframe = 0; melem = 0; active = 0; pending = 0; waiting = 0;
            mmode = 0; movf = 0; done_at = -1;
        end else begin
            if (out_valid_o && out_ready_i) dut_log.push_back({out_frame_o, out_last_o, out_data_o});
            if (done_o) ndone++;
            if (core_start_o) nstarts++;
            st = exp_start_f();
            if (q.size() != 0 && out_ready_i) void'(q.pop_front());
            if (abort_i) begin
                q.delete(); active = 0; pending = 0; waiting = 0;
            end else begin
                if (waiting && core_v_i) begin
                    w.f = 3'(mframe); w.l = melem == SN - 1; w.d = core_d_i;
                    if (q.size() < DEP) q.push_back(w); else movf = 1;
                    ms[melem] = core_d_i;
                    melem = (melem + 1) % SN;
                end
                if (waiting && core_finish_i) begin
                    melem = 0; waiting = 0; fin_cyc = cyc;
                    if (mframe == NF - 1 && !mmode) begin
                        active = 0; done_at = cyc + 1;
                    end else begin
                        mframe = (mframe + 1) % NF; pending = 1; launch_at = cyc + GAP;
                    end
                end
                if (st) begin pending = 0; waiting = 1; end
                if (!active && cyc != done_at && run_i) begin
                    active = 1; pending = 1; launch_at = cyc + 1;
                    for (int i = 0; i < SN; i++) ms[i] = x_init_i[i*DW +: DW];
                    mframe = 0; melem = 0; movf = 0; mmode = mode_i;
                end
            end
            cyc++;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic [SN*DW-1:0] xs;
        foreach (ms[i]) xs[i*DW +: DW] = ms[i];
        chk("core_start", 64'(core_start_o), 64'(exp_start_f()));
        chk("busy", 64'(busy_o), 64'(active));
        chk("done", 64'(done_o), 64'(cyc == done_at && !abort_i));
        chk("overflow", 64'(overflow_o), 64'(movf));
        chk("out_valid", 64'(out_valid_o), 64'(q.size() != 0));
        if (q.size() != 0) chk("out_word", 64'({out_frame_o, out_last_o, out_data_o}), 64'(q[0]));
        chk("core_state", 64'(core_state_o), 64'(xs));
        chk("z_addr", 64'(z_addr_o), 64'(mframe*COL + int'(obs_i)));
        chk("k_addr", 64'(k_addr_o), 64'(mframe*COL*COL + int'(kad_i)));
    end

    // Output-ready pattern and random core ROM indices.
    initial forever begin
        @(posedge clk); #2;
        out_ready_i = rdy_mode == 2 ? ($urandom % 4 != 0) : rdy_mode[0];
        if (!fix_addr) begin
            obs_i = 8'($urandom_range(0, COL - 1));
            kad_i = 15'($urandom_range(0, COL*COL - 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        fails++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_run(input bit m, input logic [SN*DW-1:0] x);
        mode_i = m; x_init_i = x; run_i = 1;
        tick();
        run_i = 0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (core_start_o) ok = 1; else tick();
        end
        if (ok) begin gap_seen = cyc - fin_cyc; st_at = cyc; end
        else begin
            checks++; fails++;
            $display("FAIL start_timeout cyc=%0d actual=no_start required=start", cyc);
        end
    endtask

    // Core stand-in: after a launch, returns state word + 1 for each word.
    task automatic serve(input int nw, input bit fin_with_last);
        bit ok;
        int e;
        wait_start(ok);
        if (!ok) return;
        tick();
        e = 0;
        for (int w = 0; w < nw; w++) begin
            repeat ($urandom_range(0, 2)) tick();
            core_v_i = 1; core_d_i = ms[e] + 1; e = (e + 1) % SN;
            core_finish_i = (w == nw - 1) && fin_with_last;
            tick();
            core_v_i = 0; core_finish_i = 0;
        end
        if (!fin_with_last) begin
            repeat ($urandom_range(0, 2)) tick();
            core_finish_i = 1;
            tick();
            core_finish_i = 0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy_o; i++) tick();
        if (busy_o) begin
            checks++; fails++;
            $display("FAIL idle_timeout cyc=%0d actual=busy required=idle", cyc);
        end
        repeat (4) tick();
    endtask

    initial begin
        word_t w;
        int n0;
        repeat (3) tick();
        chk("rst_valid", 64'(out_valid_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_state", 64'(core_state_o), 0);
        rst_n = 1;
        tick();

        // single pass, always ready
        rdy_mode = 1; ndone = 0; dut_log.delete();
        start_run(0, {32'd100, 32'd10});
        chk("run_to_start", 64'(core_start_o), 1);
        serve(2, 1);
        serve(2, 0);
        chk("gap_f1", 64'(gap_seen), 3);
        fix_addr = 1; obs_i = 8'd5; kad_i = 15'd7;
        #1;
        chk("z_addr_lit", 64'(z_addr_o), 197);
        chk("k_addr_lit", 64'(k_addr_o), 18439);
        fix_addr = 0;
        serve(2, 1);
        chk("gap_f2", 64'(gap_seen), 3);
        wait_idle();
        chk("done_count", 64'(ndone), 1);
        chk("busy_after", 64'(busy_o), 0);
        chk("log_len", 64'(dut_log.size()), 6);
        for (int i = 0; i < 6 && i < dut_log.size(); i++) begin
            w.f = 3'(i / 2); w.l = (i % 2) == 1;
            w.d = ((i % 2) == 1 ? 32'd100 : 32'd10) + 32'(i / 2 + 1);
            chk("log_word", 64'(dut_log[i]), 64'(w));
        end

        // backpressure: FIFO fills after frame 0 and the launch stalls
        rdy_mode = 0;
        tick();
        start_run(0, {$urandom, $urandom});
        serve(2, 1);
        n0 = nstarts;
        repeat (12) tick();
        chk("bp_no_start", 64'(nstarts), 64'(n0));
        chk("bp_busy", 64'(busy_o), 1);
        rdy_mode = 1; n0 = cyc;
        serve(2, 1);
        chk("bp_release", 64'(st_at - n0), 2);
        serve(2, 1);
        wait_idle();
        chk("bp_no_ovf", 64'(overflow_o), 0);

        // overflow: three words into a two-deep FIFO
        rdy_mode = 0;
        tick();
        start_run(0, {$urandom, $urandom});
        serve(3, 1);
        chk("ovf_set", 64'(overflow_o), 1);
        rdy_mode = 1;
        serve(2, 0);
        serve(2, 1);
        wait_idle();
        chk("ovf_sticky", 64'(overflow_o), 1);

        // continuous wrap, then abort in GAP
        dut_log.delete();
        start_run(1, {$urandom, $urandom});
        chk("ovf_cleared", 64'(overflow_o), 0);
        for (int f = 0; f < 4; f++) serve(2, 0);
        abort_i = 1;
        tick();
        abort_i = 0;
        chk("abort_busy", 64'(busy_o), 0);
        chk("abort_empty", 64'(out_valid_o), 0);
        n0 = nstarts;
        repeat (15) tick();
        chk("abort_no_start", 64'(nstarts), 64'(n0));
        chk("cont_len", 64'(dut_log.size()), 8);
        for (int i = 0; i < 8 && i < dut_log.size(); i++) begin
            n0 = dut_log[i].f;
            chk("cont_frame", 64'(n0), 64'((i / 2) % NF));
        end

        // async reset in WAIT, then a fresh pass
        rdy_mode = 2;
        start_run(0, {$urandom, $urandom});
        serve(1, 0);
        #2 rst_n = 0; core_v_i = 0;
        #1;
        chk("arst_valid", 64'(out_valid_o), 0);
        chk("arst_busy", 64'(busy_o), 0);
        chk("arst_start", 64'(core_start_o), 0);
        chk("arst_state", 64'(core_state_o), 0);
        chk("arst_zaddr", 64'(z_addr_o), 64'(obs_i));
        repeat (2) tick();
        rst_n = 1;
        tick();
        dut_log.delete();
        start_run(0, {$urandom, $urandom});
        for (int f = 0; f < NF; f++) serve(2, $urandom % 2);
        wait_idle();
        if (dut_log.size() != 0) chk("arst_frame0", 64'(dut_log[0].f), 0);

        // randomized passes
        for (int r = 0; r < 4; r++) begin
            start_run(0, {$urandom, $urandom});
            for (int f = 0; f < NF; f++) serve($urandom_range(1, 3), $urandom % 2);
            wait_idle();
            rdy_mode = 1;
            repeat (6) tick();
            rdy_mode = 2;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
